y_mem_writeback: RTL and testbench
==================================

Y_MEM_WRITEBACK -- requirements
Module: y_mem_writeback

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-002 clock  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  async active-high, clears all state.
REQ-004 ywb_enable  in  1  permits starting new commands.
REQ-005 ywb_valid  in  1  command strobe; driven from the update-Y datapath done flag.
REQ-006 ywb_ready  out  1  high when command FIFO not full and ywb_enable high.
REQ-007 ywb_yVal  in  48  {real[23:0], img[23:0]} value to store.
REQ-008 ywb_diagAddr / ywb_nonDiagAddr  in  11 each  Y SRAM row addresses.
REQ-009 ywb_diagOneHot / ywb_nonDiagOneHot  in  4 each  64-bit lane select within row.
REQ-010 ywb_memAddr  out  11;  ywb_memRdEn, ywb_memWrEn  out  1;  ywb_memRdData  in  256;  ywb_memWrData  out  256.
REQ-011 ywb_cmdDone  out  1  one-cycle pulse per completed command.
REQ-012 ywb_busy  out  1  FSM not IDLE or FIFO non-empty.
REQ-013 ywb_overflow, ywb_laneErr  out  1 each  sticky error flags.
REQ-014 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of two).

Function
REQ-015 Command accepted on rising edge with ywb_valid & ywb_ready; entry = {yVal, diagAddr, diagOneHot, nonDiagAddr, nonDiagOneHot} (78 bits).
REQ-016 ywb_valid while ywb_ready low: command dropped, ywb_overflow set.
REQ-017 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-018 FSM states: IDLE, RD_D, WR_D, RD_N, WR_N.
REQ-019 IDLE -> RD_D when FIFO non-empty and ywb_enable high; else stay IDLE.
REQ-020 RD_D: memRdEn=1, memAddr=diagAddr; -> WR_D.
REQ-021 WR_D: memWrEn=1, memAddr=diagAddr, memWrData=merge(memRdData); -> RD_N, or pop/finish if merged (REQ-025).
REQ-022 RD_N / WR_N: same as RD_D / WR_D using nonDiag fields; WR_N pops head, pulses ywb_cmdDone, -> RD_D if FIFO holds another entry and ywb_enable high, else IDLE.
REQ-023 SRAM read latency one cycle: memRdData sampled in cycle after memRdEn.
REQ-024 Merge: lane k = bits [64k+63:64k]; selected lane bits [64k+47:64k]=yVal, [64k+63:64k+48]=0; other lanes unchanged.
REQ-025 diagAddr==nonDiagAddr: single RMW, both lanes merged in WR_D; WR_D pops, pulses ywb_cmdDone; RD_N/WR_N skipped.
REQ-026 Same address and same lane: one lane write only.
REQ-027 One-hot not exactly one bit set: that half's write suppressed (no memWrEn), ywb_laneErr set, command still completes.
REQ-028 Latency: accept on edge E0, RD_D after E1, WR_D after E2, RD_N after E3, WR_N after E4; back-to-back throughput 4 cycles/command.
REQ-029 ywb_enable low mid-command: current command completes; no new command starts.
REQ-030 memRdEn and memWrEn SHALL never be high in the same cycle; memAddr/memWrData = 0 when neither is high.

Reset
REQ-031 Reset SHALL force IDLE, FIFO empty, all outputs 0 (ywb_ready 0 during reset), flags cleared.
REQ-032 Reset mid-command aborts it; no partial write after reset deasserts.

Structure
REQ-033 Shared package holds lane width (64), value width (48), address width (11), row width (256), FSM state encoding.
REQ-034 Command FIFO SHALL be sub-module ywb_cmd_fifo (push/pop/full/empty, registered storage).

Verification
REQ-035 Single cmd yVal=0xABCDEF123456, diag=5/0001, nonDiag=9/0100, rows all 0xFF -> row5 lane0=0x0000ABCDEF123456, row9 lane2 same, other lanes 0xFF; ywb_cmdDone after E4.
REQ-036 diag=nonDiag=7, onehots 0001/1000 -> exactly one memWrEn, row7 lanes0,3 updated, done after E2.
REQ-037 Push 5 commands back-to-back, enable high, no pops possible -> 5th dropped, ywb_overflow=1, 4 commands written in order.
REQ-038 diagOneHot=0011 -> no diag write, nonDiag written, ywb_laneErr=1.
REQ-039 Reset asserted in WR_N-preceding RD_N cycle -> no further memWrEn, busy=0, FIFO empty.
REQ-040 ywb_enable dropped during RD_D with 2 queued -> first completes, second waits until enable returns.

Source files
------------

// File: rtl/y_mem_writeback_pkg.sv
// rtl/y_mem_writeback_pkg.sv - shared widths, state encoding and lane-merge helpers for the Y writeback block
package y_mem_writeback_pkg;

    localparam int LANE_W = 64;
    localparam int VAL_W  = 48;
    localparam int ADDR_W = 11;
    localparam int ROW_W  = 256;
    localparam int LANES  = 4;
    localparam int CMD_W  = VAL_W + 2 * (ADDR_W + LANES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_D = 3'd1,
        ST_WR_D = 3'd2,
        ST_RD_N = 3'd3,
        ST_WR_N = 3'd4
    } ywb_state_t;

    typedef struct packed {
        logic [VAL_W-1:0]  y_val;
        logic [ADDR_W-1:0] diag_addr;
        logic [LANES-1:0]  diag_sel;
        logic [ADDR_W-1:0] nondiag_addr;
        logic [LANES-1:0]  nondiag_sel;
    } ywb_cmd_t;

    // True when exactly one lane is selected.
    function automatic logic onehot_ok(input logic [LANES-1:0] sel);
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

    // Replace the selected lane with the zero-extended value; other lanes pass through.
    function automatic logic [ROW_W-1:0] merge_row(input logic [ROW_W-1:0] row,
                                                   input logic [VAL_W-1:0] val,
                                                   input logic [LANES-1:0] sel,
                                                   input logic en);
        logic [ROW_W-1:0] r;
        r = row;
        for (int k = 0; k < LANES; k++) begin
            if (en && sel[k]) begin
                r[k*LANE_W +: LANE_W] = {{(LANE_W-VAL_W){1'b0}}, val};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/y_mem_writeback_cmd_fifo.sv
// rtl/y_mem_writeback_cmd_fifo.sv - command FIFO with head and next-entry peek
module ywb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 78
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         next_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_next;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rd_next = rd_ptr_q + 1'b1;
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_next];

    // Storage, pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/y_mem_writeback.sv
// rtl/y_mem_writeback.sv - queued read-modify-write of Y values into diagonal and off-diagonal SRAM rows
module y_mem_writeback
    import y_mem_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ywb_enable,
    input  logic              ywb_valid,
    output logic              ywb_ready,
    input  logic [47:0]       ywb_yVal,
    input  logic [10:0]       ywb_diagAddr,
    input  logic [10:0]       ywb_nonDiagAddr,
    input  logic [3:0]        ywb_diagOneHot,
    input  logic [3:0]        ywb_nonDiagOneHot,
    output logic [10:0]       ywb_memAddr,
    output logic              ywb_memRdEn,
    output logic              ywb_memWrEn,
    input  logic [255:0]      ywb_memRdData,
    output logic [255:0]      ywb_memWrData,
    output logic              ywb_cmdDone,
    output logic              ywb_busy,
    output logic              ywb_overflow,
    output logic              ywb_laneErr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ywb_state_t        state_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              overflow_q;
    logic              lane_err_q;

    ywb_cmd_t          cmd_in;
    ywb_cmd_t          head;
    ywb_cmd_t          next_head;
    logic [CMD_W-1:0]  head_raw;
    logic [CMD_W-1:0]  next_raw;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              push;
    logic              pop;
    logic              same_addr;
    logic              diag_ok;
    logic              ndiag_ok;
    logic              more_cmds;
    logic [ROW_W-1:0]  wr_data_d;

    assign cmd_in = '{y_val: ywb_yVal, diag_addr: ywb_diagAddr, diag_sel: ywb_diagOneHot,
                      nondiag_addr: ywb_nonDiagAddr, nondiag_sel: ywb_nonDiagOneHot};

    // Ready is held low while reset is asserted, not just after the first clock.
    assign ywb_ready = !reset && !fifo_full && ywb_enable;
    assign push      = ywb_valid && ywb_ready;
    assign head      = head_raw;
    assign next_head = next_raw;
    assign same_addr = (head.diag_addr == head.nondiag_addr);
    assign diag_ok   = onehot_ok(head.diag_sel);
    assign ndiag_ok  = onehot_ok(head.nondiag_sel);
    assign more_cmds = (fifo_count > CW'(1)) && ywb_enable;
    assign pop       = (state_q == ST_WR_N) || ((state_q == ST_WR_D) && same_addr);

    ywb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (cmd_in),
        .pop_i       (pop),
        .head_o      (head_raw),
        .next_o      (next_raw),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Sequencer: registered strobes/address follow the state; write permission is decided on entry to a write state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            lane_err_q <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            if (ywb_valid && !ywb_ready) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && ywb_enable) begin
                        state_q <= ST_RD_D;
                        rd_en_q <= 1'b1;
                        addr_q  <= head.diag_addr;
                    end
                end
                ST_RD_D: begin
                    state_q <= ST_WR_D;
                    if (diag_ok || (same_addr && ndiag_ok)) begin
                        wr_en_q <= 1'b1;
                        addr_q  <= head.diag_addr;
                    end
                    if (!diag_ok || (same_addr && !ndiag_ok)) begin
                        lane_err_q <= 1'b1;
                    end
                    done_q <= same_addr;
                end
                ST_WR_D: begin
                    if (!same_addr) begin
                        state_q <= ST_RD_N;
                        rd_en_q <= 1'b1;
                        addr_q  <= head.nondiag_addr;
                    end else if (more_cmds) begin
                        state_q <= ST_RD_D;
                        rd_en_q <= 1'b1;
                        addr_q  <= next_head.diag_addr;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_N: begin
                    state_q <= ST_WR_N;
                    done_q  <= 1'b1;
                    if (ndiag_ok) begin
                        wr_en_q <= 1'b1;
                        addr_q  <= head.nondiag_addr;
                    end else begin
                        lane_err_q <= 1'b1;
                    end
                end
                ST_WR_N: begin
                    if (more_cmds) begin
                        state_q <= ST_RD_D;
                        rd_en_q <= 1'b1;
                        addr_q  <= next_head.diag_addr;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write data is merged from the read data returned in the write cycle itself.
    always_comb begin
        wr_data_d = '0;
        if (wr_en_q) begin
            if (state_q == ST_WR_D) begin
                wr_data_d = merge_row(ywb_memRdData, head.y_val, head.diag_sel, diag_ok);
                if (same_addr) begin
                    wr_data_d = merge_row(wr_data_d, head.y_val, head.nondiag_sel, ndiag_ok);
                end
            end else begin
                wr_data_d = merge_row(ywb_memRdData, head.y_val, head.nondiag_sel, 1'b1);
            end
        end
    end

    assign ywb_memAddr   = addr_q;
    assign ywb_memRdEn   = rd_en_q;
    assign ywb_memWrEn   = wr_en_q;
    assign ywb_memWrData = wr_data_d;
    assign ywb_cmdDone   = done_q;
    assign ywb_busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign ywb_overflow  = overflow_q;
    assign ywb_laneErr   = lane_err_q;

endmodule

// File: tb/tb_y_mem_writeback.sv
// tb/tb_y_mem_writeback.sv - directed table-driven bench for y_mem_writeback
module tb_y_mem_writeback;

    localparam logic [63:0] LF = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ywb_enable = 1'b1;
    logic         ywb_valid = 1'b0;
    logic         ywb_ready;
    logic [47:0]  ywb_yVal = '0;
    logic [10:0]  ywb_diagAddr = '0;
    logic [10:0]  ywb_nonDiagAddr = '0;
    logic [3:0]   ywb_diagOneHot = '0;
    logic [3:0]   ywb_nonDiagOneHot = '0;
    logic [10:0]  ywb_memAddr;
    logic         ywb_memRdEn;
    logic         ywb_memWrEn;
    logic [255:0] ywb_memRdData = '0;
    logic [255:0] ywb_memWrData;
    logic         ywb_cmdDone;
    logic         ywb_busy;
    logic         ywb_overflow;
    logic         ywb_laneErr;

    y_mem_writeback #(.FIFO_DEPTH(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .ywb_enable        (ywb_enable),
        .ywb_valid         (ywb_valid),
        .ywb_ready         (ywb_ready),
        .ywb_yVal          (ywb_yVal),
        .ywb_diagAddr      (ywb_diagAddr),
        .ywb_nonDiagAddr   (ywb_nonDiagAddr),
        .ywb_diagOneHot    (ywb_diagOneHot),
        .ywb_nonDiagOneHot (ywb_nonDiagOneHot),
        .ywb_memAddr       (ywb_memAddr),
        .ywb_memRdEn       (ywb_memRdEn),
        .ywb_memWrEn       (ywb_memWrEn),
        .ywb_memRdData     (ywb_memRdData),
        .ywb_memWrData     (ywb_memWrData),
        .ywb_cmdDone       (ywb_cmdDone),
        .ywb_busy          (ywb_busy),
        .ywb_overflow      (ywb_overflow),
        .ywb_laneErr       (ywb_laneErr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int excl_err = 0;
    int idle_err = 0;
    logic init_req = 1'b0;
    logic [255:0] mem [2048];
    logic [10:0] wr_log [$];
    int done_cyc [$];

    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, bulk fill to all-ones on request.
    always @(posedge clock) begin
        if (init_req) begin
            for (int a = 0; a < 2048; a++) mem[a] <= '1;
        end else begin
            if (ywb_memRdEn) ywb_memRdData <= mem[ywb_memAddr];
            if (ywb_memWrEn) begin
                mem[ywb_memAddr] <= ywb_memWrData;
                wr_log.push_back(ywb_memAddr);
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (ywb_cmdDone) begin
            done_cnt <= done_cnt + 1;
            done_cyc.push_back(cyc);
        end
        if (ywb_memRdEn && ywb_memWrEn) excl_err <= excl_err + 1;
        if (!ywb_memRdEn && !ywb_memWrEn && (ywb_memAddr != '0 || ywb_memWrData != '0)) idle_err <= idle_err + 1;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ywb_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic init_mem();
        init_req = 1'b1;
        @(posedge clock);
        #1 init_req = 1'b0;
    endtask

    task automatic drive(input logic [47:0] y, input logic [10:0] da, input logic [3:0] ds,
                         input logic [10:0] na, input logic [3:0] ns);
        ywb_valid = 1'b1;
        ywb_yVal = y;
        ywb_diagAddr = da;
        ywb_diagOneHot = ds;
        ywb_nonDiagAddr = na;
        ywb_nonDiagOneHot = ns;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(posedge clock);
            #1;
            if (!ywb_busy) break;
        end
        if (n == budget) check(name, 256'(ywb_busy), 256'(0));
    endtask

    typedef struct {
        logic [47:0]  y;
        logic [10:0]  da;
        logic [3:0]   ds;
        logic [10:0]  na;
        logic [3:0]   ns;
        logic [255:0] exp_d;
        logic [255:0] exp_n;
        int           exp_wr;
        int           exp_lat;
        logic         exp_lerr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat, w0, d0, snap;
        logic [47:0] yv;

        vecs[0] = '{48'hABCDEF123456, 11'd5, 4'b0001, 11'd9, 4'b0100,
                    {LF, LF, LF, 64'h0000ABCDEF123456}, {LF, 64'h0000ABCDEF123456, LF, LF}, 2, 4, 1'b0};
        vecs[1] = '{48'h111122223333, 11'd7, 4'b0001, 11'd7, 4'b1000,
                    {64'h0000111122223333, LF, LF, 64'h0000111122223333},
                    {64'h0000111122223333, LF, LF, 64'h0000111122223333}, 1, 2, 1'b0};
        vecs[2] = '{48'h000000000001, 11'd3, 4'b0010, 11'd3, 4'b0010,
                    {LF, LF, 64'h0000000000000001, LF}, {LF, LF, 64'h0000000000000001, LF}, 1, 2, 1'b0};
        vecs[3] = '{48'hCAFE00BEEF11, 11'd10, 4'b0011, 11'd11, 4'b1000,
                    {LF, LF, LF, LF}, {64'h0000CAFE00BEEF11, LF, LF, LF}, 1, 4, 1'b1};
        vecs[4] = '{48'h123456789ABC, 11'd12, 4'b0000, 11'd12, 4'b0100,
                    {LF, 64'h0000123456789ABC, LF, LF}, {LF, 64'h0000123456789ABC, LF, LF}, 1, 2, 1'b1};
        vecs[5] = '{48'h00000000BEEF, 11'd20, 4'b1000, 11'd21, 4'b0101,
                    {64'h00000000000BEEF, LF, LF, LF}, {LF, LF, LF, LF}, 1, 4, 1'b1};
        vecs[5].exp_d = {64'h000000000000BEEF, LF, LF, LF};

        // Reset state with enable high: ready must still be low.
        #2;
        check("reset_ready", 256'(ywb_ready), 256'(0));
        check("reset_flags", 256'({ywb_busy, ywb_memRdEn, ywb_memWrEn, ywb_cmdDone, ywb_overflow, ywb_laneErr}), 256'(0));
        check("reset_addr_data", {ywb_memWrData[255:11], ywb_memAddr}, 256'(0));

        for (int v = 0; v < 6; v++) begin
            do_reset();
            init_mem();
            w0 = wr_cnt;
            d0 = done_cnt;
            @(negedge clock);
            drive(vecs[v].y, vecs[v].da, vecs[v].ds, vecs[v].na, vecs[v].ns);
            check($sformatf("v%0d_ready", v), 256'(ywb_ready), 256'(1));
            @(posedge clock);
            #1 ywb_valid = 1'b0;
            lat = 0;
            for (int n = 1; n <= 20; n++) begin
                @(posedge clock);
                #1;
                if (ywb_cmdDone) begin
                    lat = n;
                    break;
                end
            end
            check($sformatf("v%0d_done_latency", v), 256'(lat), 256'(vecs[v].exp_lat));
            repeat (3) @(posedge clock);
            #1;
            check($sformatf("v%0d_row_diag", v), mem[vecs[v].da], vecs[v].exp_d);
            check($sformatf("v%0d_row_nondiag", v), mem[vecs[v].na], vecs[v].exp_n);
            check($sformatf("v%0d_write_count", v), 256'(wr_cnt - w0), 256'(vecs[v].exp_wr));
            check($sformatf("v%0d_done_count", v), 256'(done_cnt - d0), 256'(1));
            check($sformatf("v%0d_lane_err", v), 256'(ywb_laneErr), 256'(vecs[v].exp_lerr));
            check($sformatf("v%0d_idle", v), 256'({ywb_busy, ywb_overflow}), 256'(0));
        end

        // Five back-to-back pushes: the fifth meets a full FIFO and is dropped.
        do_reset();
        init_mem();
        snap = wr_log.size();
        d0 = done_cyc.size();
        for (int i = 0; i < 5; i++) begin
            drive(48'h100 + 48'(i), 11'(32 + 2*i), 4'(1 << (i % 4)), 11'(33 + 2*i), 4'(1 << ((i + 1) % 4)));
            if (i == 4) check("ovf_ready_when_full", 256'(ywb_ready), 256'(0));
            @(posedge clock);
            #1;
        end
        ywb_valid = 1'b0;
        check("ovf_flag", 256'(ywb_overflow), 256'(1));
        wait_idle("ovf_drain_timeout", 100);
        repeat (2) @(posedge clock);
        #1;
        check("ovf_write_count", 256'(wr_log.size() - snap), 256'(8));
        for (int k = 0; k < 8; k++) begin
            if (snap + k < wr_log.size())
                check($sformatf("ovf_order_%0d", k), 256'(wr_log[snap + k]), 256'(32 + k));
        end
        check("ovf_done_count", 256'(done_cyc.size() - d0), 256'(4));
        if (done_cyc.size() - d0 == 4)
            check("ovf_throughput", 256'(done_cyc[d0 + 3] - done_cyc[d0]), 256'(12));
        check("ovf_row36_lane2", 256'(mem[36][191:128]), 256'(64'h0000000000000102));
        check("ovf_row40_untouched", mem[40], '1);
        check("ovf_row41_untouched", mem[41], '1);

        // Reset during the off-diagonal read aborts the command.
        do_reset();
        init_mem();
        @(negedge clock);
        yv = 48'h5A5A5A5A5A5A;
        drive(yv, 11'd50, 4'b0001, 11'd51, 4'b0010);
        @(posedge clock);
        #1 ywb_valid = 1'b0;
        lat = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (ywb_memRdEn && ywb_memAddr == 11'd51) begin
                lat = 1;
                break;
            end
        end
        check("rst_saw_rd_n", 256'(lat), 256'(1));
        reset = 1'b1;
        snap = wr_cnt;
        #1;
        check("rst_outputs", 256'({ywb_busy, ywb_ready, ywb_memRdEn, ywb_memWrEn}), 256'(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("rst_no_write", 256'(wr_cnt - snap), 256'(0));
        check("rst_busy", 256'(ywb_busy), 256'(0));
        check("rst_row51", mem[51], '1);
        check("rst_row50", mem[50], {LF, LF, LF, 16'h0, yv});

        // Enable dropped during RD_D with two queued commands.
        do_reset();
        init_mem();
        d0 = done_cnt;
        @(negedge clock);
        drive(48'hAAAA0000AAAA, 11'd60, 4'b0001, 11'd61, 4'b0001);
        @(posedge clock);
        #1 drive(48'hBBBB0000BBBB, 11'd62, 4'b0010, 11'd63, 4'b0010);
        @(posedge clock);
        #1;
        ywb_valid = 1'b0;
        ywb_enable = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        check("en_first_done", 256'(done_cnt - d0), 256'(1));
        check("en_still_busy", 256'(ywb_busy), 256'(1));
        check("en_row61", mem[61], {LF, LF, LF, 64'h0000AAAA0000AAAA});
        check("en_row63_waiting", mem[63], '1);
        ywb_enable = 1'b1;
        wait_idle("en_resume_timeout", 40);
        repeat (2) @(posedge clock);
        #1;
        check("en_second_done", 256'(done_cnt - d0), 256'(2));
        check("en_row63", mem[63], {LF, LF, 64'h0000BBBB0000BBBB, LF});
        check("en_no_overflow", 256'(ywb_overflow), 256'(0));

        check("rd_wr_exclusive", 256'(excl_err), 256'(0));
        check("idle_bus_zero", 256'(idle_err), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
